prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Writer side of the SISC instruction memory: accepts a byte stream (valid/ready), packs
//  big-endian 32-bit instruction words and writes them to im at consecutive addresses from 0.
//  Holds the sisc core in reset (cpu_rst_f low) until the whole image is loaded, then releases it.
//  Sits between the host byte link and im/sisc in the top-level testbench/system.
// PARAMETERS
//  ADDR_W   16  im word-address width (matches 16-bit pc)
//  DATA_W   32  instruction width; must be 32 (4 bytes/word)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_f      in   1       asynchronous reset, active low
//  in_valid   in   1       byte present on in_data
//  in_data    in   8       stream byte
//  in_ready   out  1       loader can accept a byte this cycle
//  im_we      out  1       one-cycle write strobe to instruction memory
//  im_addr    out  ADDR_W  word address for im write
//  im_wdata   out  DATA_W  packed instruction word
//  cpu_rst_f  out  1       reset to sisc core, active low; high only after successful load
//  done       out  1       image loaded (sticky until rst_f)
//  err        out  1       load failed (sticky until rst_f; only with LOADER_CSUM_EN)
// BEHAVIOUR
//  Reset (rst_f=0, async): state=HDR_HI, in_ready=0, im_we=0, im_addr=0, im_wdata=0,
//   cpu_rst_f=0, done=0, err=0, count/byte index cleared. in_ready rises the first clk after release.
//  Byte accepted iff in_valid && in_ready on a rising edge; in_data must be stable while in_valid=1.
//  Stream format: count[15:8], count[7:0], then count words x 4 bytes, MSB first (byte0 -> [31:24]).
//  FSM: HDR_HI -accept-> HDR_LO -accept-> (count==0 ? END : DATA)
//       DATA: 4th byte of a word -> im_we=1 next cycle with im_wdata=packed word, im_addr=current;
//             im_addr increments the cycle after the strobe; last word -> END.
//       END -> DONE (no checksum) or CSUM (with LOADER_CSUM_EN).
//       DONE/ERR: terminal, in_ready=0, bytes ignored; leave only via rst_f.
//  in_ready=1 in HDR_HI, HDR_LO, DATA, CSUM; 0 in END, DONE, ERR and in the im_we cycle
//   (one bubble per word; no byte is dropped or duplicated).
//  count=0xFFFF: 65535 words, addresses 0..0xFFFE, no address wrap; count=0: no writes, DONE.
//  cpu_rst_f and done rise together, registered, one cycle after DONE entered.
//  in_valid held low mid-word: state and partial word held indefinitely (no timeout).
//  rst_f mid-load: everything to reset values; words already in im remain, next image overwrites from 0.
// CONFIGURATION
//  LOADER_CSUM_EN defined: after the last word, one extra byte = XOR of all count and payload
//   bytes; match -> DONE (cpu_rst_f=1, done=1); mismatch -> ERR (err=1, cpu_rst_f stays 0).
//  LOADER_CSUM_EN undefined: no checksum byte, no CSUM/ERR state, err tied 0.
// STRUCTURE
//  sisc_pkg: loader state enum (HDR_HI, HDR_LO, DATA, END, CSUM, DONE, ERR), BYTES_PER_WORD=4,
//   HDR_BYTES=2.
//  Sub-module byte_pack: 4-byte shift/pack register + 2-bit byte index, outputs word and word_full.
//  prog_loader top holds the FSM, word counter, address counter, checksum accumulator.
// TESTING
//  1. count=0x0002, words 0x11223344, 0xAABBCCDD -> im[0]=0x11223344, im[1]=0xAABBCCDD, two
//     im_we pulses, then cpu_rst_f=1, done=1.
//  2. count=0x0000 -> no im_we, done=1 and cpu_rst_f=1 after second header byte + 2 cycles.
//  3. Random in_valid gaps (50% duty) over 8 words -> identical im contents and strobe count to
//     gap-free run; in_ready=0 in each im_we cycle.
//  4. Assert rst_f=0 after 6 bytes of a 3-word load -> all outputs at reset values immediately;
//     reload 1 word 0xDEADBEEF -> im[0]=0xDEADBEEF, done=1.
//  5. LOADER_CSUM_EN, count=1, word 0x01020304, csum 0x05 (0x00^0x01^1^2^3^4) -> done=1;
//     csum 0x06 -> err=1, cpu_rst_f=0, in_ready=0.
//  6. Bytes offered after done -> in_ready=0, no im_we, im contents unchanged.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types for the instruction-memory loader.
// LOADER_CSUM_EN enables the trailing checksum byte and the CSUM/ERR states.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        END,
        CSUM,
        DONE,
        ERR
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/prog_loader_byte_pack.sv
// Packs four stream bytes MSB-first into one 32-bit instruction word.
// word_full_o flags the push that completes a word; word_o is valid then.
module prog_loader_byte_pack
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [23:0] sh_q;
    logic [1:0]  idx_q;

    assign word_o      = {sh_q, byte_i};
    assign word_full_o = push_i && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (push_i) begin
            sh_q  <= {sh_q[15:0], byte_i};
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a counted byte image into instruction memory, then releases the core.
// LOADER_CSUM_EN: expect an XOR checksum byte after the last word.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst_f,
    output logic              done,
    output logic              err
);

    ld_state_e         state_q, state_d;
    logic              rdy_q;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       left_q, left_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic              done_q, err_q;
    logic              acc, push, full;
    logic [31:0]       word;

    // the write-strobe cycle is the one bubble per word
    assign in_ready = rdy_q && !we_q &&
                      (state_q inside {HDR_HI, HDR_LO, DATA, CSUM});
    assign acc  = in_valid && in_ready;
    assign push = acc && (state_q == DATA);

    prog_loader_byte_pack u_byte_pack (
        .clk         (clk),
        .rst_f       (rst_f),
        .push_i      (push),
        .byte_i      (in_data),
        .word_o      (word),
        .word_full_o (full)
    );

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        left_d  = left_q;
        hi_d    = hi_q;
        csum_d  = acc ? (csum_q ^ in_data) : csum_q;
        unique case (state_q)
            HDR_HI: if (acc) begin
                hi_d    = in_data;
                state_d = HDR_LO;
            end
            HDR_LO: if (acc) begin
                left_d  = {hi_q, in_data};
                state_d = ({hi_q, in_data} == 16'd0) ? END : DATA;
            end
            DATA: if (full) begin
                we_d    = 1'b1;
                wdata_d = word;
                left_d  = left_q - 16'd1;
                if (left_q == 16'd1) state_d = END;
            end
`ifdef LOADER_CSUM_EN
            END:  state_d = CSUM;
`else
            END:  state_d = DONE;
`endif
            CSUM: if (acc) begin
                state_d = (in_data == csum_q) ? DONE : ERR;
            end
            DONE, ERR: ;
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= HDR_HI;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            if (we_q) addr_q <= addr_q + ADDR_W'(1);
            left_q  <= left_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            done_q  <= done_q | (state_q == DONE);
            err_q   <= err_q | (state_q == ERR);
        end
    end

    assign im_we     = we_q;
    assign im_addr   = addr_q;
    assign im_wdata  = wdata_q;
    assign cpu_rst_f = done_q;
    assign done      = done_q;
`ifdef LOADER_CSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
